gouram_trace_drain: RTL and testbench

- Consumer end of the Gouram trace port.
- Accepts 128-bit trace records qualified by the trace capture-enable strobe and buffers them in a small FIFO.
- Serialises each record into 32-bit beats on a valid/ready stream toward the debug transport (UART/JTAG bridge).
- Reports FIFO-full back-pressure and counts records dropped on overflow, since the tracer cannot stall.

---
 rtl/gouram_trace_drain_if.sv | 22 ++
 rtl/gouram_trace_drain.sv | 142 ++++++++++++++
 tb/tb_gouram_trace_drain.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gouram_trace_drain_if.sv
// Gouram trace drain output stream: 32-bit valid/ready beats with
// an end-of-record marker toward the debug transport.
interface gouram_trace_drain_if;
   logic [31:0] m_data_o;
   logic        m_valid_o;
   logic        m_ready_i;
   logic        m_last_o;

   modport master (
      output m_data_o,
      output m_valid_o,
      output m_last_o,
      input  m_ready_i
   );

   modport slave (
      input  m_data_o,
      input  m_valid_o,
      input  m_last_o,
      output m_ready_i
   );
endinterface

// File: rtl/gouram_trace_drain.sv
// Gouram trace drain: buffers 128-bit trace records and serialises them
// into 32-bit beats; GOURAM_TRACE_DRAIN_HEADER_EN adds a header beat.
module gouram_trace_drain #(
   parameter int FIFO_DEPTH     = 4,
   parameter int DROP_CNT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [127:0]              trace_data_i,
   input  logic                      trace_capture_enable_i,
   gouram_trace_drain_if.master      m,
   output logic                      fifo_full_o,
   output logic [DROP_CNT_WIDTH-1:0] drop_count_o,
   output logic                      busy_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef GOURAM_TRACE_DRAIN_HEADER_EN
   localparam int NBEATS = 5;
`else
   localparam int NBEATS = 4;
`endif
   localparam logic [2:0] LAST_IDX = 3'(NBEATS - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t                    state_q, state_d;
   logic [127:0]              mem [FIFO_DEPTH];
   logic [AW:0]               wptr_q, rptr_q;
   logic [127:0]              sreg_q;
   logic [2:0]                idx_q;
   logic [DROP_CNT_WIDTH-1:0] drop_q;

   logic empty, full, push, drop, xfer, last_beat, pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   // full is pre-edge occupancy: a same-edge pop never rescues a capture
   assign push = trace_capture_enable_i && !full;
   assign drop = trace_capture_enable_i && full;

   assign xfer      = (state_q == SEND) && m.m_ready_i;
   assign last_beat = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (xfer && last_beat) begin
               if (!empty) pop = 1'b1;
               else        state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wptr_q[AW-1:0]] <= trace_data_i;
            wptr_q              <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     drop_q <= '0;
      else if (drop && drop_q != '1)  drop_q <= drop_q + 1'b1;
   end

`ifdef GOURAM_TRACE_DRAIN_HEADER_EN
   logic [15:0] seq_q;
   logic [31:0] hdr_q;
   logic [15:0] drop16;
   logic [15:0] seq_snap;

   assign drop16 = 16'(drop_q);
   // a back-to-back pop sees the record that just completed
   assign seq_snap = (xfer && last_beat) ? seq_q + 16'd1 : seq_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seq_q <= '0;
         hdr_q <= '0;
      end else begin
         if (xfer && last_beat) seq_q <= seq_q + 16'd1;
         if (pop)               hdr_q <= {drop16, seq_snap};
      end
   end

   assign m.m_data_o = (idx_q == 3'd0) ? hdr_q : sreg_q[31:0];
`else
   assign m.m_data_o = sreg_q[31:0];
`endif

   logic shift_en;
`ifdef GOURAM_TRACE_DRAIN_HEADER_EN
   assign shift_en = (idx_q != 3'd0);
`else
   assign shift_en = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg_q <= '0;
         idx_q  <= '0;
      end else if (pop) begin
         sreg_q <= mem[rptr_q[AW-1:0]];
         idx_q  <= '0;
      end else if (xfer) begin
         idx_q <= last_beat ? 3'd0 : idx_q + 3'd1;
         if (shift_en) sreg_q <= {32'd0, sreg_q[127:32]};
      end
   end

   assign m.m_valid_o  = (state_q == SEND);
   assign m.m_last_o   = (state_q == SEND) && last_beat;
   assign fifo_full_o  = full;
   assign drop_count_o = drop_q;
   assign busy_o       = !empty || (state_q == SEND);

endmodule

// File: tb/tb_gouram_trace_drain.sv
// Bench for gouram_trace_drain: directed phases plus random traffic,
// checked every cycle against a queue-based record/beat model.
module tb_gouram_trace_drain;

   localparam int DEPTH = 4;
   localparam int DW    = 16;
   localparam int MAXD  = (1 << DW) - 1;
`ifdef GOURAM_TRACE_DRAIN_HEADER_EN
   localparam int NB = 5;
`else
   localparam int NB = 4;
`endif
   localparam logic [127:0] REC0 =
      128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] REC1 =
      128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [127:0]  tdata;
   logic          cap;
   logic          full;
   logic [DW-1:0] dcnt;
   logic          busy;

   gouram_trace_drain_if bus ();

   gouram_trace_drain #(
      .FIFO_DEPTH     (DEPTH),
      .DROP_CNT_WIDTH (DW)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .trace_data_i           (tdata),
      .trace_capture_enable_i (cap),
      .m                      (bus),
      .fifo_full_o            (full),
      .drop_count_o           (dcnt),
      .busy_o                 (busy)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // model: FIFO contents, record in flight, beat index, counters
   logic [127:0] q[$];
   bit           infl;
   logic [127:0] cur;
   int           idx;
   logic [31:0]  hdr;
   int           drops;
   int           seq;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_beat();
`ifdef GOURAM_TRACE_DRAIN_HEADER_EN
      if (idx == 0) return hdr;
      return cur[32*(idx-1) +: 32];
`else
      return cur[32*idx +: 32];
`endif
   endfunction

   task automatic model_reset();
      q.delete();
      infl  = 1'b0;
      cur   = '0;
      idx   = 0;
      hdr   = '0;
      drops = 0;
      seq   = 0;
   endtask

   task automatic model_step(bit c, logic [127:0] d, bit r);
      int          pre;
      logic [31:0] pd;
      logic [31:0] sq;
      pre = q.size();
      pd  = drops;
      if (infl && r) begin
         if (idx == NB - 1) begin
            infl = 1'b0;
            seq  = (seq + 1) & 16'hFFFF;
         end else begin
            idx++;
         end
      end
      if (!infl && pre > 0) begin
         cur  = q.pop_front();
         idx  = 0;
         infl = 1'b1;
         sq   = seq;
         hdr  = {pd[15:0], sq[15:0]};
      end
      if (c) begin
         if (pre == DEPTH) begin
            if (drops < MAXD) drops++;
         end else begin
            q.push_back(d);
         end
      end
   endtask

   task automatic check_outputs();
      check("valid", bus.m_valid_o, infl);
      check("last", bus.m_last_o, infl && idx == NB - 1);
      if (infl) check("data", bus.m_data_o, exp_beat());
      check("full", full, q.size() == DEPTH);
      check("drop", dcnt, drops);
      check("busy", busy, q.size() > 0 || infl);
   endtask

   task automatic cycle(bit c, logic [127:0] d, bit r);
      @(negedge clk);
      check_outputs();
      cap           = c;
      tdata         = d;
      bus.m_ready_i = r;
      @(posedge clk);
      model_step(c, d, r);
   endtask

   function automatic logic [127:0] rnd_rec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      rst_n         = 1'b0;
      cap           = 1'b0;
      tdata         = '0;
      bus.m_ready_i = 1'b0;
      model_reset();
      #13;
      check("rst_data", bus.m_data_o, 32'd0);
      check_outputs();
      rst_n = 1'b1;

      // single record, ready high
      cycle(1'b1, REC0, 1'b1);
      repeat (7) cycle(1'b0, '0, 1'b1);

      // back-pressure pattern 1,0,0
      cycle(1'b1, REC1, 1'b1);
      for (int i = 0; i < 18; i++) cycle(1'b0, '0, (i % 3) == 0);
      repeat (4) cycle(1'b0, '0, 1'b1);

      // overflow with ready low, then drain back-to-back
      for (int i = 0; i < 6; i++) cycle(1'b1, rnd_rec(), 1'b0);
      repeat (30) cycle(1'b0, '0, 1'b1);

      // full FIFO: capture lands on the edge of a last-beat pop
      for (int i = 0; i < 5; i++) cycle(1'b1, rnd_rec(), 1'b0);
      repeat (NB - 1) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, rnd_rec(), 1'b1);
      repeat (30) cycle(1'b0, '0, 1'b1);

      // drop counter saturation
      for (int i = 0; i < 65545; i++) cycle(1'b1, REC1, 1'b0);
      check("drop_sat", dcnt, 32'h0000FFFF);
      cycle(1'b1, REC0, 1'b0);
      repeat (30) cycle(1'b0, '0, 1'b1);

      // asynchronous reset after two beats of a record
      cycle(1'b1, REC1, 1'b1);
      for (int i = 0; i < 10 && !(infl && idx == 2); i++)
         cycle(1'b0, '0, 1'b1);
      check("reach_beat2", idx, 2);
      @(negedge clk);
      cap = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("ar_valid", bus.m_valid_o, 32'd0);
      check("ar_data", bus.m_data_o, 32'd0);
      check("ar_last", bus.m_last_o, 32'd0);
      check("ar_full", full, 32'd0);
      check("ar_drop", dcnt, 32'd0);
      check("ar_busy", busy, 32'd0);
      model_reset();
      #5 rst_n = 1'b1;
      repeat (3) cycle(1'b0, '0, 1'b1);
      cycle(1'b1, REC0, 1'b1);
      cycle(1'b1, REC1, 1'b1);
      repeat (14) cycle(1'b0, '0, 1'b1);

      // random traffic
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 99) < 35, rnd_rec(),
               $urandom_range(0, 99) < 70);
      repeat (40) cycle(1'b0, '0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
